// File: rtl/rgb_pwm_ctrl.sv
// rgb_pwm_ctrl
// Runs one shared period counter for the R/G/B channels of the mixer and
// compares it against per-channel duty values to produce PWM outputs.
// New colour triples arrive over a valid/ready port into a shadow buffer.
// They are copied into the active duty registers only at a period boundary,
// or when the counter starts from IDLE, so an output never glitches mid-period.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high, clears all state
//   enable       level: 1 = run, 0 = finish current period then stop
//   cfg_valid    a new R/G/B triple is present on cfg_r/cfg_g/cfg_b
//   cfg_ready    shadow buffer empty, triple will be accepted
//   cfg_r/g/b    duty values, WIDTH bits each
//   pwm_r/g/b    PWM outputs
//   period_start one-cycle pulse on the first clk of every period
//   busy         counter running (RUN or DRAIN)
//   count        current period counter value
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | counter stopped at 0, outputs low, waiting for enable
// RUN   | counter running, enable high
// DRAIN | enable dropped; counter runs to the end of the period
module rgb_pwm_ctrl #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_r,
    input  logic [WIDTH-1:0] cfg_g,
    input  logic [WIDTH-1:0] cfg_b,
    output logic             pwm_r,
    output logic             pwm_g,
    output logic             pwm_b,
    output logic             period_start,
    output logic             busy,
    output logic [WIDTH-1:0] count
);

    // A 1-bit prescaler is kept even for PRESCALE=1; it then stays at 0 and
    // tick is asserted every cycle.
    localparam int              PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PS_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [PW-1:0]      presc_q,   presc_d;
    logic [WIDTH-1:0]   count_q,   count_d;
    logic [3*WIDTH-1:0] shadow_q,  shadow_d;
    logic [3*WIDTH-1:0] active_q,  active_d;
    logic               pending_q, pending_d;
    logic               pstart_q,  pstart_d;

    logic tick;
    logic boundary;
    logic handshake;
    logic load;

    assign tick      = (state_q != S_IDLE) && (presc_q == PS_LAST);
    assign boundary  = tick && (count_q == CNT_MAX);
    assign handshake = cfg_valid && !pending_q;

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        count_d  = count_q;
        pstart_d = 1'b0;
        load     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d  = S_RUN;
                    presc_d  = '0;
                    count_d  = '0;
                    pstart_d = 1'b1;
                    load     = pending_q;
                end
            end
            S_RUN, S_DRAIN: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick) begin
                    count_d = count_q + 1'b1;
                end
                // pending_q is the pre-edge value, so a triple accepted in
                // the boundary cycle itself waits for the next boundary.
                load = boundary && pending_q;
                // enable takes priority over the drain-complete exit.
                if (enable) begin
                    state_d = S_RUN;
                end else if (state_q == S_RUN) begin
                    state_d = S_DRAIN;
                end else if (boundary) begin
                    state_d = S_IDLE;
                end
                pstart_d = boundary && (state_d != S_IDLE);
            end
            default: begin
                state_d = S_IDLE;
                presc_d = '0;
                count_d = '0;
            end
        endcase
    end

    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (handshake) begin
            shadow_d  = {cfg_r, cfg_g, cfg_b};
            pending_d = 1'b1;
        end
        // load and handshake are mutually exclusive: load needs pending_q,
        // handshake needs !pending_q.
        if (load) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            count_q   <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            pstart_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            count_q   <= count_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            pstart_q  <= pstart_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign cfg_ready    = !pending_q;
    assign count        = count_q;
    assign period_start = pstart_q;
    assign pwm_r        = busy && (count_q < active_q[3*WIDTH-1 -: WIDTH]);
    assign pwm_g        = busy && (count_q < active_q[2*WIDTH-1 -: WIDTH]);
    assign pwm_b        = busy && (count_q < active_q[WIDTH-1   -: WIDTH]);

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Bench for rgb_pwm_ctrl: one instance with PRESCALE=1 and one with PRESCALE=4.
// The reference model tracks elapsed clocks since the counter started.
// From those it derives the count, the period position and the clock at
// which a buffered triple becomes active.
module tb_rgb_pwm_ctrl;
    localparam int W = 8;
    localparam int N = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [W-1:0] cfg_r, cfg_g, cfg_b;
    logic         en_1, vld_1, en_4, vld_4;
    logic         rdy_1, pr_1, pg_1, pb_1, ps_1, bsy_1;
    logic         rdy_4, pr_4, pg_4, pb_4, ps_4, bsy_4;
    logic [W-1:0] cnt_1, cnt_4;

    rgb_pwm_ctrl #(.WIDTH(W), .PRESCALE(1)) u_dut1 (
        .clk(clk), .reset(reset), .enable(en_1), .cfg_valid(vld_1), .cfg_ready(rdy_1),
        .cfg_r(cfg_r), .cfg_g(cfg_g), .cfg_b(cfg_b),
        .pwm_r(pr_1), .pwm_g(pg_1), .pwm_b(pb_1),
        .period_start(ps_1), .busy(bsy_1), .count(cnt_1)
    );

    rgb_pwm_ctrl #(.WIDTH(W), .PRESCALE(4)) u_dut4 (
        .clk(clk), .reset(reset), .enable(en_4), .cfg_valid(vld_4), .cfg_ready(rdy_4),
        .cfg_r(cfg_r), .cfg_g(cfg_g), .cfg_b(cfg_b),
        .pwm_r(pr_4), .pwm_g(pg_4), .pwm_b(pb_4),
        .period_start(ps_4), .busy(bsy_4), .count(cnt_4)
    );

    logic         o_rdy [2], o_pr [2], o_pg [2], o_pb [2], o_ps [2], o_bsy [2];
    logic [W-1:0] o_cnt [2];
    always_comb begin
        o_rdy[0] = rdy_1; o_pr[0] = pr_1; o_pg[0] = pg_1; o_pb[0] = pb_1;
        o_ps[0]  = ps_1;  o_bsy[0] = bsy_1; o_cnt[0] = cnt_1;
        o_rdy[1] = rdy_4; o_pr[1] = pr_4; o_pg[1] = pg_4; o_pb[1] = pb_4;
        o_ps[1]  = ps_4;  o_bsy[1] = bsy_4; o_cnt[1] = cnt_4;
    end

    int    n_cmp  = 0;
    int    n_fail = 0;
    int    P  [2] = '{1, 4};
    string nm [2] = '{"p1", "p4"};

    // reference model
    bit m_run   [2];
    int m_t     [2];   // clocks since the counter started
    bit m_drain [2];   // enable was low at the previous edge
    int m_act   [2][3];
    bit m_pend  [2];
    int m_pd    [2][3];
    int m_apply [2];   // clock index at which the pending triple goes live; -1 = at start

    int hr, hg, hb, nps, nr0, nchg;

    task automatic model_clear(input int i);
        m_run[i] = 0; m_t[i] = 0; m_drain[i] = 0; m_pend[i] = 0; m_apply[i] = -1;
        for (int c = 0; c < 3; c++) begin
            m_act[i][c] = 0;
            m_pd[i][c]  = 0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) model_clear(i);
    endtask

    task automatic m_load(input int i);
        for (int c = 0; c < 3; c++) m_act[i][c] = m_pd[i][c];
        m_pend[i] = 0;
    endtask

    function automatic int exp_count(input int i);
        return m_run[i] ? (m_t[i] / P[i]) % N : 0;
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int L, pre_t;
            bit e, v, hs, pre_run, bnd;
            L = N * P[i];
            e = (i == 0) ? en_1 : en_4;
            v = (i == 0) ? vld_1 : vld_4;
            if (reset) begin
                model_clear(i);
            end else begin
                hs      = v && !m_pend[i];
                pre_run = m_run[i];
                pre_t   = m_t[i];
                if (!pre_run) begin
                    if (e) begin
                        m_run[i] = 1; m_t[i] = 0; m_drain[i] = 0;
                        if (m_pend[i]) m_load(i);
                    end
                end else begin
                    bnd = (pre_t % L) == L - 1;
                    if (m_pend[i] && (pre_t + 1 == m_apply[i])) m_load(i);
                    if (bnd && m_drain[i] && !e) begin
                        m_run[i] = 0; m_t[i] = 0;
                    end else begin
                        m_t[i] = pre_t + 1;
                    end
                    m_drain[i] = !e;
                end
                if (hs) begin
                    m_pend[i] = 1;
                    m_pd[i][0] = int'(cfg_r); m_pd[i][1] = int'(cfg_g); m_pd[i][2] = int'(cfg_b);
                    if (!m_run[i])    m_apply[i] = -1;
                    else if (!pre_run) m_apply[i] = L;
                    else m_apply[i] = (pre_t / L + 1) * L + (((pre_t % L) == L - 1) ? L : 0);
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int L, c;
            L = N * P[i];
            c = exp_count(i);
            chk($sformatf("%s count", nm[i]),  32'(o_cnt[i]), c);
            chk($sformatf("%s busy", nm[i]),   32'(o_bsy[i]), 32'(m_run[i]));
            chk($sformatf("%s ready", nm[i]),  32'(o_rdy[i]), 32'(!m_pend[i]));
            chk($sformatf("%s pwm_r", nm[i]),  32'(o_pr[i]),  32'(m_run[i] && c < m_act[i][0]));
            chk($sformatf("%s pwm_g", nm[i]),  32'(o_pg[i]),  32'(m_run[i] && c < m_act[i][1]));
            chk($sformatf("%s pwm_b", nm[i]),  32'(o_pb[i]),  32'(m_run[i] && c < m_act[i][2]));
            chk($sformatf("%s pstart", nm[i]), 32'(o_ps[i]),  32'(m_run[i] && (m_t[i] % L) == 0));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic wait_cnt(input int i, input int val, input int budget);
        int k;
        k = 0;
        while (!(m_run[i] && exp_count(i) == val) && k < budget) begin
            step();
            k++;
        end
        chk($sformatf("%s wait_count_%0d", nm[i], val), 32'(m_run[i] && exp_count(i) == val), 1);
    endtask

    task automatic wait_idle(input int i, input int budget);
        int k;
        k = 0;
        while (m_run[i] && k < budget) begin
            step();
            k++;
        end
        chk($sformatf("%s wait_idle", nm[i]), 32'(m_run[i]), 0);
    endtask

    task automatic measure(input int i, input int n);
        logic [W-1:0] prev;
        hr = 0; hg = 0; hb = 0; nps = 0; nr0 = 0; nchg = 0;
        prev = o_cnt[i];
        for (int k = 0; k < n; k++) begin
            if (o_pr[i] === 1'b1) hr++;
            if (o_pg[i] === 1'b1) hg++;
            if (o_pb[i] === 1'b1) hb++;
            if (o_ps[i] === 1'b1) nps++;
            if (o_rdy[i] === 1'b0) nr0++;
            if (k > 0 && o_cnt[i] !== prev) nchg++;
            prev = o_cnt[i];
            step();
        end
    endtask

    function automatic logic [W-1:0] rnd_duty();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom_range(0, N - 1));
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        en_1 = 0; en_4 = 0; vld_1 = 0; vld_4 = 0;
        cfg_r = '0; cfg_g = '0; cfg_b = '0;
        model_reset();
        #1;
        check_all();
        repeat (3) step();
        reset = 1'b0;
        step();

        // 1: cfg while idle, then run at PRESCALE=1
        cfg_r = 8'd64; cfg_g = 8'd128; cfg_b = 8'd0; vld_1 = 1;
        step();
        vld_1 = 0;
        chk("t1 ready_after_hs", 32'(rdy_1), 0);
        step();
        en_1 = 1;
        step();
        chk("t1 first_pstart", 32'(ps_1), 1);
        chk("t1 first_pwm_r", 32'(pr_1), 1);
        measure(0, N);
        chk("t1 r_high", hr, 64);
        chk("t1 g_high", hg, 128);
        chk("t1 b_high", hb, 0);
        chk("t1 pstarts", nps, 1);
        chk("t1 next_pstart", 32'(ps_1), 1);

        // 2: mid-period update takes effect at the next boundary
        wait_cnt(0, 100, 300);
        cfg_r = 8'd200; vld_1 = 1;
        step();
        vld_1 = 0;
        chk("t2 ready_low", 32'(rdy_1), 0);
        wait_cnt(0, 0, 300);
        chk("t2 ready_back", 32'(rdy_1), 1);
        measure(0, N);
        chk("t2 r_high", hr, 200);
        chk("t2 g_high", hg, 128);

        // 3: handshake in the boundary cycle waits a full period
        wait_cnt(0, 255, 300);
        cfg_r = 8'd30; vld_1 = 1;
        step();
        vld_1 = 0;
        measure(0, N);
        chk("t3 old_r_high", hr, 200);
        chk("t3 ready_low_cycles", nr0, 256);
        measure(0, N);
        chk("t3 new_r_high", hr, 30);
        chk("t3 ready_low_after", nr0, 0);

        // 4: drain with re-enable, then drain to idle
        wait_cnt(0, 10, 300);
        en_1 = 0;
        step();
        wait_cnt(0, 100, 300);
        en_1 = 1;
        step();
        chk("t4 no_restart_count", 32'(cnt_1), 101);
        chk("t4 busy_reenable", 32'(bsy_1), 1);
        wait_cnt(0, 10, 300);
        en_1 = 0;
        wait_cnt(0, 255, 300);
        chk("t4 busy_last", 32'(bsy_1), 1);
        step();
        chk("t4 idle_busy", 32'(bsy_1), 0);
        chk("t4 idle_count", 32'(cnt_1), 0);
        chk("t4 idle_pwm_r", 32'(pr_1), 0);
        repeat (4) step();

        // 5: async reset mid-period
        cfg_r = 8'd220; cfg_g = 8'd5; cfg_b = 8'd250; vld_1 = 1;
        step();
        vld_1 = 0;
        en_1 = 1;
        step();
        wait_cnt(0, 150, 300);
        chk("t5 pwm_r_before", 32'(pr_1), 1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("t5 async_pwm_r", 32'(pr_1), 0);
        chk("t5 async_count", 32'(cnt_1), 0);
        chk("t5 async_ready", 32'(rdy_1), 1);
        step();
        reset = 1'b0;
        step();
        chk("t5 rerun_busy", 32'(bsy_1), 1);
        measure(0, N);
        chk("t5 r_zero", hr, 0);
        chk("t5 g_zero", hg, 0);
        chk("t5 b_zero", hb, 0);
        en_1 = 0;
        wait_idle(0, 600);

        // 6: PRESCALE=4
        cfg_r = 8'd255; cfg_g = 8'd0; cfg_b = 8'd128; vld_4 = 1;
        step();
        vld_4 = 0;
        en_4 = 1;
        step();
        measure(1, 4 * N);
        chk("t6 r_high", hr, 1020);
        chk("t6 g_high", hg, 0);
        chk("t6 b_high", hb, 512);
        chk("t6 count_steps", nchg, 255);
        chk("t6 pstarts", nps, 1);
        en_4 = 0;
        wait_idle(1, 2200);

        // randomized traffic on both instances
        en_1 = 1; en_4 = 1;
        for (int k = 0; k < 8000; k++) begin
            if ($urandom_range(0, 299) == 0) en_1 = ~en_1;
            if ($urandom_range(0, 299) == 0) en_4 = ~en_4;
            vld_1 = ($urandom_range(0, 39) == 0);
            vld_4 = ($urandom_range(0, 39) == 0);
            cfg_r = rnd_duty(); cfg_g = rnd_duty(); cfg_b = rnd_duty();
            if (k == 4000) begin
                #2 reset = 1'b1;
                #1;
                model_reset();
                check_all();
                step();
                reset = 1'b0;
            end
            step();
        end
        vld_1 = 0; vld_4 = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_ctrl.md
Name: rgb_pwm_ctrl

Overview:
Controller that sequences one shared period counter across the three colour channels (R, G, B) of the mixer and turns per-channel duty values into PWM outputs. A valid/ready port double-buffers new colour settings, and they take effect only on a period boundary, so there are no glitches. A run/drain state machine starts the counter and stops it cleanly at the end of a period. The block sits between the register/config front end and the LED drivers.

Parameters:
WIDTH, 8, bit width of the period counter and of each duty value; period = 2^WIDTH ticks.
PRESCALE, 4, clk cycles per counter tick (legal range >= 1).

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  asynchronous, active-high; clears all state.
enable  input  1  level; 1 = run PWM, 0 = drain then stop.
cfg_valid  input  1  a new R/G/B triple is present.
cfg_ready  output  1  the shadow buffer is empty and can accept a triple.
cfg_r  input  WIDTH  red duty.
cfg_g  input  WIDTH  green duty.
cfg_b  input  WIDTH  blue duty.
pwm_r  output  1  red PWM.
pwm_g  output  1  green PWM.
pwm_b  output  1  blue PWM.
period_start  output  1  one-cycle pulse on the first clk of every period.
busy  output  1  1 in RUN or DRAIN.
count  output  WIDTH  current period counter value (debug/observe).

Behaviour:
- Reset (async, any time, including mid-period):
  - state=IDLE; prescaler=0; count=0.
  - shadow, active duty registers and pending flag all cleared.
  - Outputs: cfg_ready=1, pwm_*=0, period_start=0, busy=0.
- Prescaler:
  - In RUN/DRAIN it counts 0..PRESCALE-1 and wraps.
  - tick=1 in the cycle where prescaler==PRESCALE-1.
  - With PRESCALE=1, tick is 1 every cycle.
- Counter:
  - Increments by 1 on tick; wraps from 2^WIDTH-1 to 0 (modulo, no saturation).
  - boundary = tick && count==2^WIDTH-1.
- Config handshake:
  - cfg_ready = !pending.
  - Transfer occurs on a clk edge with cfg_valid && cfg_ready: shadow <= {cfg_r, cfg_g, cfg_b}, pending <= 1.
  - Once the handshake completes, the cfg inputs are not sampled again until pending clears.
- Shadow-to-active load happens on either:
  - the IDLE->RUN transition, or
  - a boundary while pending==1.
  - On load: active <= shadow, pending <= 0.
- Handshake and boundary in the same cycle:
  - The load uses the pre-edge pending value (0), so it does not fire.
  - The new triple sits in shadow for one full period.
  - There is no bypass path.
- State machine:
  - IDLE:
    - enable=1 -> RUN; prescaler=0, count=0.
    - If pending, load shadow to active on the same edge.
  - RUN:
    - enable=0 -> DRAIN. The counter keeps running.
  - DRAIN:
    - enable=1 -> RUN with no counter restart.
    - boundary -> IDLE; count held at 0.
    - If both happen in the same cycle, enable wins: stay running and take the normal boundary actions.
- PWM:
  - pwm_x = busy && (count < active_x), combinational from registered state.
  - Duty 0 -> constant low.
  - Duty 2^WIDTH-1 -> high for 2^WIDTH-1 of 2^WIDTH ticks.
  - 100% duty is not representable.
- period_start:
  - Registered.
  - 1 in the first RUN cycle after IDLE.
  - 1 in the cycle after each boundary that remains in RUN/DRAIN.
  - Never 1 in IDLE.
- Latency:
  - enable rise to first pwm high = 1 clk (when active_x > 0).
  - cfg handshake to visible effect = next boundary, at most 2^WIDTH*PRESCALE clks.
- busy = (state != IDLE).

Test Plan:
1. Reset, then PRESCALE=1; send cfg (r=64, g=128, b=0) while IDLE; enable=1 -> per 256-cycle period: pwm_r high for 64 cycles, pwm_g for 128, pwm_b never; period_start every 256 cycles.
2. While running at r=64, send r=200 mid-period -> cfg_ready=0 until the boundary; the next period shows pwm_r high for 200 cycles; cfg_ready returns to 1 one cycle after the boundary.
3. Handshake exactly in the boundary cycle -> the old duty persists for one more full period, the new duty applies after the following boundary, and cfg_ready stays 0 for 256 cycles.
4. Drop enable at count=10 -> busy stays 1 until count wraps, then IDLE with pwm_*=0 and count=0. Reassert enable at count=100 during DRAIN -> no restart; count continues at 101.
5. Assert reset at count=150 with pwm_r high -> pwm_*=0, count=0, cfg_ready=1 immediately (async); after release, the active duty reads 0 (no output until new cfg plus enable).
6. PRESCALE=4: duty r=255 -> pwm_r high for 1020 of 1024 cycles; duty 0 -> pwm low throughout; count advances once every 4 clks.
